// File: rtl/serv_state_wide_if.sv
// Handshake, decode-status and control bundle between serv_state_wide and its neighbours.
// master is the state block; slave is the decode/ALU/bus/RF side.
interface serv_state_wide_if;
  logic       new_irq;
  logic       debug_req;
  logic       step_en;
  logic       ibus_ack;
  logic       dbus_ack;
  logic       rf_ready;
  logic       cond_branch;
  logic       bne_or_bge;
  logic       alu_cmp;
  logic       branch_op;
  logic       mem_op;
  logic       shift_op;
  logic       sh_right;
  logic       slt_op;
  logic       e_op;
  logic       rd_op;
  logic       ctrl_misalign;
  logic       mem_misalign;
  logic       alu_sh_done;
  logic       alu_sh_done_r;

  logic       ibus_cyc;
  logic       dbus_cyc;
  logic       rf_rreq;
  logic       rf_wreq;
  logic       rf_rd_en;
  logic       init;
  logic       cnt_en;
  logic       cnt0;
  logic       cnt0to3;
  logic       cnt12to31;
  logic       cnt_done;
  logic [4:0] cnt;
  logic [1:0] mem_bytecnt;
  logic       ctrl_pc_en;
  logic       ctrl_jump;
  logic       ctrl_trap;
  logic       alu_shamt_en;
  logic       bufreg_en;
  logic       pending_irq;
  logic       debug;
  logic       debug_we;

  modport master (
    input  new_irq, debug_req, step_en, ibus_ack, dbus_ack, rf_ready,
           cond_branch, bne_or_bge, alu_cmp, branch_op, mem_op, shift_op,
           sh_right, slt_op, e_op, rd_op, ctrl_misalign, mem_misalign,
           alu_sh_done, alu_sh_done_r,
    output ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, rf_rd_en, init, cnt_en,
           cnt0, cnt0to3, cnt12to31, cnt_done, cnt, mem_bytecnt, ctrl_pc_en,
           ctrl_jump, ctrl_trap, alu_shamt_en, bufreg_en, pending_irq, debug,
           debug_we
  );

  modport slave (
    output new_irq, debug_req, step_en, ibus_ack, dbus_ack, rf_ready,
           cond_branch, bne_or_bge, alu_cmp, branch_op, mem_op, shift_op,
           sh_right, slt_op, e_op, rd_op, ctrl_misalign, mem_misalign,
           alu_sh_done, alu_sh_done_r,
    input  ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, rf_rd_en, init, cnt_en,
           cnt0, cnt0to3, cnt12to31, cnt_done, cnt, mem_bytecnt, ctrl_pc_en,
           ctrl_jump, ctrl_trap, alu_shamt_en, bufreg_en, pending_irq, debug,
           debug_we
  );
endinterface

// File: rtl/serv_state_wide.sv
// Control-state sequencer for a W-bit-per-cycle serial datapath: fetch, RF requests,
// two-stage op sequencing, branch decision, misalign/IRQ traps and debug halt/step.
module serv_state_wide #(
  parameter int unsigned W              = 1,
  parameter string       RESET_STRATEGY = "MINI",
  parameter bit          WITH_CSR       = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst,
  serv_state_wide_if.master bus
);
  localparam int unsigned   CW      = 5;
  localparam bit            RST_ALL = (RESET_STRATEGY != "NONE");
  localparam logic [CW-1:0] STEP    = CW'(W);
  localparam logic [CW-1:0] LAST    = CW'(32 - W);

  if (!(W == 1 || W == 2 || W == 4)) begin : g_bad_w
    $error("serv_state_wide: W must be 1, 2 or 4");
  end

  logic [CW-1:0] cnt_q;
  logic cnt_en_q, init_done_q, ctrl_jump_q, stage_two_req_q, ibus_cyc_q;
  logic irq_sync_q, pending_irq_q, dbg_sync_q, debug_q, dbg_req_q, misalign_sync_q;

  logic two_stage, init, cnt_done, pc_en, take_branch, trap_pending, ctrl_trap;
  logic pending_irq, debug, dbg_rise, step_halt;

  always_comb begin
    pending_irq  = WITH_CSR & pending_irq_q;
    debug        = WITH_CSR & debug_q;
    two_stage    = bus.slt_op | bus.mem_op | bus.branch_op | bus.shift_op;
    init         = two_stage & !pending_irq & !debug & !init_done_q;
    cnt_done     = cnt_en_q & (cnt_q == LAST);
    pc_en        = cnt_en_q & !init;
    take_branch  = bus.branch_op & (!bus.cond_branch | (bus.alu_cmp ^ bus.bne_or_bge));
    trap_pending = WITH_CSR & ((ctrl_jump_q & bus.ctrl_misalign) | (bus.mem_op & bus.mem_misalign));
    ctrl_trap    = WITH_CSR & (bus.e_op | pending_irq | misalign_sync_q | debug);
    dbg_rise     = bus.debug_req & !dbg_req_q;
    // Step halts only on the retiring phase of a normal instruction.
    step_halt    = bus.step_en & cnt_done & !init & !debug;
  end

  // Phase counter and two-stage sequencing state.
  always_ff @(posedge i_clk) begin
    if (i_rst && RST_ALL) begin
      cnt_q           <= '0;
      cnt_en_q        <= 1'b0;
      init_done_q     <= 1'b0;
      ctrl_jump_q     <= 1'b0;
      stage_two_req_q <= 1'b0;
      misalign_sync_q <= 1'b0;
    end else begin
      if (cnt_en_q) cnt_q <= cnt_q + STEP;
      if (cnt_done) cnt_en_q <= 1'b0;
      else if (!cnt_en_q && bus.rf_ready) cnt_en_q <= 1'b1;
      if (cnt_done) begin
        init_done_q <= init & !init_done_q;
        ctrl_jump_q <= init & take_branch;
      end
      stage_two_req_q <= cnt_done & init;
      if (stage_two_req_q) misalign_sync_q <= trap_pending;
      else if (cnt_done) misalign_sync_q <= 1'b0;
    end
  end

  // Fetch request: raised by reset so the core fetches straight out of reset.
  always_ff @(posedge i_clk) begin
    if (bus.ibus_ack || cnt_done || i_rst) ibus_cyc_q <= pc_en | i_rst;
  end

  // IRQ/debug synchronisers; debug wins at fetch and leaves the IRQ pending.
  always_ff @(posedge i_clk) begin
    if (i_rst && RST_ALL) begin
      irq_sync_q    <= 1'b0;
      pending_irq_q <= 1'b0;
      dbg_sync_q    <= 1'b0;
      debug_q       <= 1'b0;
      dbg_req_q     <= 1'b0;
    end else begin
      dbg_req_q <= bus.debug_req;
      if (bus.new_irq) irq_sync_q <= 1'b1;
      else if (bus.ibus_ack && !dbg_sync_q) irq_sync_q <= 1'b0;
      if (dbg_rise || step_halt) dbg_sync_q <= 1'b1;
      else if (bus.ibus_ack) dbg_sync_q <= 1'b0;
      if (bus.ibus_ack) begin
        pending_irq_q <= irq_sync_q & !dbg_sync_q;
        debug_q       <= dbg_sync_q;
      end
    end
  end

  assign bus.ibus_cyc     = ibus_cyc_q & !i_rst;
  assign bus.dbus_cyc     = !cnt_en_q & init_done_q & bus.mem_op & !bus.mem_misalign;
  assign bus.rf_rreq      = bus.ibus_ack | (stage_two_req_q & trap_pending);
  assign bus.rf_wreq      = !i_rst & !trap_pending &
                            ((bus.shift_op & (bus.alu_sh_done | !bus.sh_right) & init_done_q) |
                             (bus.mem_op & bus.dbus_ack) |
                             (stage_two_req_q & (bus.slt_op | bus.branch_op)));
  assign bus.rf_rd_en     = bus.rd_op & pc_en;
  assign bus.init         = init;
  assign bus.cnt_en       = cnt_en_q;
  assign bus.cnt0         = cnt_en_q & (cnt_q == '0);
  assign bus.cnt0to3      = cnt_q < CW'(4);
  assign bus.cnt12to31    = cnt_q >= CW'(12);
  assign bus.cnt_done     = cnt_done;
  assign bus.cnt          = cnt_q;
  assign bus.mem_bytecnt  = cnt_q[4:3];
  assign bus.ctrl_pc_en   = pc_en;
  assign bus.ctrl_jump    = ctrl_jump_q;
  assign bus.ctrl_trap    = ctrl_trap;
  assign bus.alu_shamt_en = cnt_en_q & ((cnt_q < CW'(5)) | !init);
  assign bus.bufreg_en    = (cnt_en_q & (init | ctrl_trap | bus.branch_op)) |
                            (bus.shift_op & !stage_two_req_q & (bus.sh_right | bus.alu_sh_done_r));
  assign bus.pending_irq  = pending_irq;
  assign bus.debug        = debug;
  assign bus.debug_we     = debug & pc_en;
endmodule

// File: tb/tb_serv_state_wide.sv
// Bench for serv_state_wide: W=1/2/4 instances share stimulus; one is observed per test.
module tb_serv_state_wide;
  typedef struct packed {
    logic cond_branch, bne_or_bge, alu_cmp, branch_op, mem_op, shift_op, sh_right;
    logic slt_op, e_op, rd_op, ctrl_misalign, mem_misalign, alu_sh_done, alu_sh_done_r;
  } op_t;

  typedef struct packed {
    logic rst, new_irq, debug_req, step_en, ibus_ack, dbus_ack, rf_ready;
    op_t  op;
  } in_t;

  typedef struct packed {
    logic       ibus_cyc, dbus_cyc, rf_rreq, rf_wreq, rf_rd_en, init, cnt_en;
    logic       cnt0, cnt0to3, cnt12to31, cnt_done;
    logic [4:0] cnt;
    logic [1:0] mem_bytecnt;
    logic       ctrl_pc_en, ctrl_jump, ctrl_trap, alu_shamt_en, bufreg_en;
    logic       pending_irq, debug, debug_we;
  } out_t;

  typedef struct packed {
    logic       en;
    logic [4:0] cnt;
    logic       done, init, jump, rreq, wreq, icyc, dcyc, trap, irq, dbg;
  } key_t;

  typedef struct {
    string       name;
    int unsigned sel;
    in_t         stim;
    int unsigned n;
    key_t        exp;
  } vec_t;

  localparam op_t OP_ADD = op_t'{rd_op: 1'b1, default: 1'b0};
  localparam op_t OP_BEQ = op_t'{branch_op: 1'b1, cond_branch: 1'b1, alu_cmp: 1'b1, default: 1'b0};
  localparam op_t OP_LWM = op_t'{mem_op: 1'b1, mem_misalign: 1'b1, rd_op: 1'b1, default: 1'b0};
  localparam op_t OP_SLT = op_t'{slt_op: 1'b1, rd_op: 1'b1, default: 1'b0};

  logic        clk;
  in_t         stim;
  out_t        outs [3];
  out_t        o;
  int unsigned sel;
  int          checks;
  int          errors;
  vec_t        vecs [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WG = 1 << g;
    serv_state_wide_if bus ();
    assign bus.new_irq       = stim.new_irq;
    assign bus.debug_req     = stim.debug_req;
    assign bus.step_en       = stim.step_en;
    assign bus.ibus_ack      = stim.ibus_ack;
    assign bus.dbus_ack      = stim.dbus_ack;
    assign bus.rf_ready      = stim.rf_ready;
    assign bus.cond_branch   = stim.op.cond_branch;
    assign bus.bne_or_bge    = stim.op.bne_or_bge;
    assign bus.alu_cmp       = stim.op.alu_cmp;
    assign bus.branch_op     = stim.op.branch_op;
    assign bus.mem_op        = stim.op.mem_op;
    assign bus.shift_op      = stim.op.shift_op;
    assign bus.sh_right      = stim.op.sh_right;
    assign bus.slt_op        = stim.op.slt_op;
    assign bus.e_op          = stim.op.e_op;
    assign bus.rd_op         = stim.op.rd_op;
    assign bus.ctrl_misalign = stim.op.ctrl_misalign;
    assign bus.mem_misalign  = stim.op.mem_misalign;
    assign bus.alu_sh_done   = stim.op.alu_sh_done;
    assign bus.alu_sh_done_r = stim.op.alu_sh_done_r;

    serv_state_wide #(.W(WG), .RESET_STRATEGY("MINI"), .WITH_CSR(1'b1)) dut (
      .i_clk (clk),
      .i_rst (stim.rst),
      .bus   (bus)
    );

    assign outs[g] = out_t'{bus.ibus_cyc, bus.dbus_cyc, bus.rf_rreq, bus.rf_wreq, bus.rf_rd_en,
                            bus.init, bus.cnt_en, bus.cnt0, bus.cnt0to3, bus.cnt12to31,
                            bus.cnt_done, bus.cnt, bus.mem_bytecnt, bus.ctrl_pc_en,
                            bus.ctrl_jump, bus.ctrl_trap, bus.alu_shamt_en, bus.bufreg_en,
                            bus.pending_irq, bus.debug, bus.debug_we};
  end

  always_comb o = outs[sel];

  function automatic in_t mk(op_t op, logic rst, logic ack, logic rdy, logic irq);
    in_t s = '0;
    s.op       = op;
    s.rst      = rst;
    s.ibus_ack = ack;
    s.rf_ready = rdy;
    s.new_irq  = irq;
    return s;
  endfunction

  function automatic key_t k(logic en, int unsigned cnt, logic done, logic init, logic jump,
                             logic rreq, logic wreq, logic icyc, logic dcyc, logic trap,
                             logic irq, logic dbg);
    return key_t'{en, 5'(cnt), done, init, jump, rreq, wreq, icyc, dcyc, trap, irq, dbg};
  endfunction

  function automatic key_t key_of(out_t x);
    return key_t'{x.cnt_en, x.cnt, x.cnt_done, x.init, x.ctrl_jump, x.rf_rreq, x.rf_wreq,
                  x.ibus_cyc, x.dbus_cyc, x.ctrl_trap, x.pending_irq, x.debug};
  endfunction

  task automatic add(string name, int unsigned s, in_t st, int unsigned n, key_t e);
    vec_t v;
    v.name = name; v.sel = s; v.stim = st; v.n = n; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(op_t op);
    stim = mk(op, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2);
    stim.rst = 1'b0;
  endtask

  task automatic fetch();
    stim.ibus_ack = 1'b1;
    step(1);
    stim.ibus_ack = 1'b0;
  endtask

  task automatic start();
    stim.rf_ready = 1'b1;
    step(1);
    stim.rf_ready = 1'b0;
  endtask

  task automatic finish_phase(string name);
    for (int i = 0; i < 40; i++) begin
      if (o.cnt_done) break;
      step(1);
    end
    chk(name, 32'(o.cnt_done), 32'd1);
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned cnt;
    checks = 0;
    errors = 0;
    sel    = 0;
    stim   = mk(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);

    // W=1 ADD: fetch on reset, 32-cycle phase, refetch.
    add("w1 reset",   0, mk(OP_ADD, 1, 0, 0, 0),  2, k(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("w1 rstfetch",0, mk(OP_ADD, 0, 0, 0, 0),  1, k(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    add("w1 ack",     0, mk(OP_ADD, 0, 1, 0, 0),  1, k(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add("w1 start",   0, mk(OP_ADD, 0, 0, 1, 0),  1, k(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("w1 run",     0, mk(OP_ADD, 0, 0, 0, 0), 30, k(1, 30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("w1 last",    0, mk(OP_ADD, 0, 0, 0, 0),  1, k(1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add("w1 refetch", 0, mk(OP_ADD, 0, 0, 0, 0),  1, k(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // W=4 BEQ taken.
    add("beq reset",  2, mk(OP_BEQ, 1, 0, 0, 0),  2, k(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("beq ack",    2, mk(OP_BEQ, 0, 1, 0, 0),  1, k(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    add("beq start",  2, mk(OP_BEQ, 0, 0, 1, 0),  1, k(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("beq run",    2, mk(OP_BEQ, 0, 0, 0, 0),  6, k(1, 24, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("beq last1",  2, mk(OP_BEQ, 0, 0, 0, 0),  1, k(1, 28, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("beq stage2", 2, mk(OP_BEQ, 0, 0, 0, 0),  1, k(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    add("beq start2", 2, mk(OP_BEQ, 0, 0, 1, 0),  1, k(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("beq last2",  2, mk(OP_BEQ, 0, 0, 0, 0),  7, k(1, 28, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    add("beq refetch",2, mk(OP_BEQ, 0, 0, 0, 0),  1, k(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    // W=2 misaligned load: no dbus, trap phase.
    add("lwm reset",  1, mk(OP_LWM, 1, 0, 0, 0),  2, k(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lwm ack",    1, mk(OP_LWM, 0, 1, 0, 0),  1, k(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    add("lwm start",  1, mk(OP_LWM, 0, 0, 1, 0),  1, k(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lwm run",    1, mk(OP_LWM, 0, 0, 0, 0), 14, k(1, 28, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lwm last1",  1, mk(OP_LWM, 0, 0, 0, 0),  1, k(1, 30, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("lwm stage2", 1, mk(OP_LWM, 0, 0, 0, 0),  1, k(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add("lwm trap0",  1, mk(OP_LWM, 0, 0, 1, 0),  1, k(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add("lwm trapend",1, mk(OP_LWM, 0, 0, 0, 0), 15, k(1, 30, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add("lwm refetch",1, mk(OP_LWM, 0, 0, 0, 0),  1, k(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    // W=4 IRQ entry on a two-stage op.
    add("irq reset",  2, mk(OP_SLT, 1, 0, 0, 0),  2, k(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    add("irq pulse",  2, mk(OP_SLT, 0, 0, 0, 1),  1, k(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    add("irq ack",    2, mk(OP_SLT, 0, 1, 0, 0),  1, k(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    add("irq start",  2, mk(OP_SLT, 0, 0, 1, 0),  1, k(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    add("irq phase",  2, mk(OP_SLT, 0, 0, 0, 0),  8, k(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    add("irq clear",  2, mk(OP_SLT, 0, 1, 0, 0),  1, k(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      sel  = vecs[i].sel;
      stim = vecs[i].stim;
      step(vecs[i].n);
      chk(vecs[i].name, 32'(key_of(o)), 32'(vecs[i].exp));
    end

    // W=4 counter walk and decodes.
    sel = 2;
    do_reset(OP_ADD);
    fetch();
    start();
    for (int i = 0; i < 8; i++) begin
      logic [4:0] c;
      c = 5'(4 * i);
      chk("w4 cnt",       32'(o.cnt), 32'(c));
      chk("w4 cnt_done",  32'(o.cnt_done), 32'(i == 7));
      chk("w4 cnt0",      32'(o.cnt0), 32'(i == 0));
      chk("w4 cnt0to3",   32'(o.cnt0to3), 32'(c < 5'd4));
      chk("w4 cnt12to31", 32'(o.cnt12to31), 32'(c >= 5'd12));
      chk("w4 bytecnt",   32'(o.mem_bytecnt), 32'(c[4:3]));
      chk("w4 pc/rd/shamt/bufreg",
          32'({o.ctrl_pc_en, o.rf_rd_en, o.alu_shamt_en, o.bufreg_en}), 32'(4'b1110));
      step(1);
    end
    chk("w4 phase end", 32'({o.cnt_en, o.cnt}), 32'd0);

    // W=1 debug halt coinciding with IRQ; held request must not re-trigger.
    sel = 0;
    do_reset(OP_ADD);
    stim.debug_req = 1'b1;
    stim.new_irq   = 1'b1;
    step(1);
    stim.new_irq = 1'b0;
    fetch();
    chk("dbg halt", 32'(o.debug), 32'd1);
    chk("dbg over irq", 32'(o.pending_irq), 32'd0);
    chk("dbg trap", 32'(o.ctrl_trap), 32'd1);
    start();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (o.debug_we) cnt++;
      if (!o.cnt_en) break;
      step(1);
    end
    chk("dbg_we cycles", cnt, 32'd32);
    fetch();
    chk("dbg no retrigger", 32'(o.debug), 32'd0);
    chk("irq after dbg", 32'(o.pending_irq), 32'd1);
    stim.debug_req = 1'b0;

    // W=2 single step: halt after one instruction retires, not after the debug one.
    sel = 1;
    do_reset(OP_ADD);
    stim.step_en = 1'b1;
    fetch();
    chk("step first fetch", 32'(o.debug), 32'd0);
    start();
    finish_phase("step phase1 done");
    fetch();
    chk("step halt", 32'(o.debug), 32'd1);
    start();
    finish_phase("step phase2 done");
    fetch();
    chk("step resume", 32'(o.debug), 32'd0);
    stim.step_en = 1'b0;

    // W=1 reset mid-phase.
    sel = 0;
    do_reset(OP_ADD);
    fetch();
    start();
    step(12);
    chk("midrst cnt", 32'(o.cnt), 32'd12);
    stim.rst = 1'b1;
    #1;
    chk("midrst wreq", 32'(o.rf_wreq), 32'd0);
    step(1);
    chk("midrst stop", 32'({o.cnt_en, o.cnt}), 32'd0);
    stim.rst = 1'b0;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
